// File: rtl/stopwatch_mmss.sv
// MM:SS stopwatch with IDLE/RUN/PAUSE control and a 4-digit multiplexed,
// active-low seven-segment driver scanned by an external tick.
module stopwatch_mmss (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_scan,
  input  logic       start_stop,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       running,
  output logic       rollover
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] s_lo_reg, s_hi_reg, m_lo_reg, m_hi_reg;
  logic [3:0] s_lo_next, s_hi_next, m_lo_next, m_hi_next;
  logic       rollover_reg, rollover_next;
  logic [1:0] idx_reg, idx_next;
  logic [6:0] seg_reg, seg_next;
  logic [3:0] an_reg, an_next;
  logic [3:0] digit_sel;
  logic       count_en;

  // The registered state qualifies counting, so a tick coincident with
  // start_stop is counted only if we were already running.
  assign count_en = (state_reg == RUN) && tick_1hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      s_lo_reg     <= 4'd0;
      s_hi_reg     <= 4'd0;
      m_lo_reg     <= 4'd0;
      m_hi_reg     <= 4'd0;
      rollover_reg <= 1'b0;
      idx_reg      <= 2'd0;
      seg_reg      <= 7'b1000000;
      an_reg       <= 4'b1110;
    end else begin
      state_reg    <= state_next;
      s_lo_reg     <= s_lo_next;
      s_hi_reg     <= s_hi_next;
      m_lo_reg     <= m_lo_next;
      m_hi_reg     <= m_hi_next;
      rollover_reg <= rollover_next;
      idx_reg      <= idx_next;
      seg_reg      <= seg_next;
      an_reg       <= an_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else if (start_stop) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    s_lo_next     = s_lo_reg;
    s_hi_next     = s_hi_reg;
    m_lo_next     = m_lo_reg;
    m_hi_next     = m_hi_reg;
    rollover_next = 1'b0;
    if (clear) begin
      s_lo_next = 4'd0;
      s_hi_next = 4'd0;
      m_lo_next = 4'd0;
      m_hi_next = 4'd0;
    end else if (count_en) begin
      if (s_lo_reg != 4'd9) begin
        s_lo_next = s_lo_reg + 4'd1;
      end else begin
        s_lo_next = 4'd0;
        if (s_hi_reg != 4'd5) begin
          s_hi_next = s_hi_reg + 4'd1;
        end else begin
          s_hi_next = 4'd0;
          if (m_lo_reg != 4'd9) begin
            m_lo_next = m_lo_reg + 4'd1;
          end else begin
            m_lo_next = 4'd0;
            if (m_hi_reg != 4'd5) begin
              m_hi_next = m_hi_reg + 4'd1;
            end else begin
              m_hi_next     = 4'd0;
              rollover_next = 1'b1;
            end
          end
        end
      end
    end
  end

  assign idx_next = tick_scan ? idx_reg + 2'd1 : idx_reg;

  always_comb begin
    case (idx_reg)
      2'd0:    digit_sel = s_lo_reg;
      2'd1:    digit_sel = s_hi_reg;
      2'd2:    digit_sel = m_lo_reg;
      default: digit_sel = m_hi_reg;
    endcase
  end

  // Decoded every cycle so the display follows digit changes between scan ticks.
  always_comb begin
    case (digit_sel)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b1111111;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_anode
      assign an_next[gi] = (idx_reg != 2'(gi));
    end
  endgenerate

  assign seg      = seg_reg;
  assign an       = an_reg;
  assign running  = (state_reg == RUN);
  assign rollover = rollover_reg;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Self-checking bench for stopwatch_mmss: a vector table, directed corner
// sequences and random stimulus, all against a seconds-count reference model.
module tb_stopwatch_mmss;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz, tick_scan, start_stop, clear;
  logic [6:0] seg;
  logic [3:0] an;
  logic       running, rollover;

  stopwatch_mmss dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .tick_scan  (tick_scan),
    .start_stop (start_stop),
    .clear      (clear),
    .seg        (seg),
    .an         (an),
    .running    (running),
    .rollover   (rollover)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed seconds, a mode number and the scan position.
  int m_secs;   // 0..3599
  int m_mode;   // 0 idle, 1 run, 2 pause
  int m_idx;    // 0..3
  logic m_roll;

  logic [6:0] dec [0:9];

  typedef struct {
    logic       tick;
    logic       scan;
    logic       ss;
    logic       clr;
    logic       run;
    logic       roll;
    logic [3:0] an;
    logic [6:0] seg;
  } vec_t;

  vec_t vt [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input int secs, input int pos);
    int s, m;
    s = secs % 60;
    m = secs / 60;
    case (pos)
      0:       return s % 10;
      1:       return s / 10;
      2:       return m % 10;
      default: return m / 10;
    endcase
  endfunction

  task automatic model_reset();
    m_secs = 0;
    m_mode = 0;
    m_idx  = 0;
    m_roll = 1'b0;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic step(input logic t, input logic sc, input logic s, input logic c);
    int pre_idx, pre_secs;
    logic [3:0] exp_an;
    tick_1hz   = t;
    tick_scan  = sc;
    start_stop = s;
    clear      = c;
    @(posedge clk);
    pre_idx  = m_idx;
    pre_secs = m_secs;
    if (c) begin
      m_mode = 0;
      m_secs = 0;
      m_roll = 1'b0;
    end else begin
      m_roll = 1'b0;
      if (m_mode == 1 && t) begin
        if (m_secs == 3599) begin
          m_secs = 0;
          m_roll = 1'b1;
        end else begin
          m_secs = m_secs + 1;
        end
      end
      if (s) m_mode = (m_mode == 1) ? 2 : 1;
    end
    if (sc) m_idx = (m_idx + 1) % 4;
    #1;
    exp_an = ~(4'b0001 << pre_idx);
    chk("seg", 32'(seg), 32'(dec[digit_of(pre_secs, pre_idx)]));
    chk("an", 32'(an), 32'(exp_an));
    chk("running", 32'(running), 32'(m_mode == 1));
    chk("rollover", 32'(rollover), 32'(m_roll));
  endtask

  // Scan all four digits and compare each against the expected MM:SS.
  task automatic check_time(input int mm, input int ss_v);
    logic [6:0] got [0:3];
    int want [0:3];
    for (int j = 0; j < 4; j++) got[j] = 7'h7f;
    want[0] = ss_v % 10;
    want[1] = ss_v / 10;
    want[2] = mm % 10;
    want[3] = mm / 10;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++)
        if (an == ~(4'b0001 << j)) got[j] = seg;
    end
    for (int j = 0; j < 4; j++)
      chk($sformatf("digit%0d", j), 32'(got[j]), 32'(dec[want[j]]));
    $display("check_time %02d:%02d running=%0b", mm, ss_v, running);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required end before %0t", $time);
    $fatal(1);
  end

  initial begin
    dec[0] = 7'b1000000; dec[1] = 7'b1111001; dec[2] = 7'b0100100;
    dec[3] = 7'b0110000; dec[4] = 7'b0011001; dec[5] = 7'b0010010;
    dec[6] = 7'b0000010; dec[7] = 7'b1111000; dec[8] = 7'b0000000;
    dec[9] = 7'b0010000;

    //          tick  scan  ss    clr   run   roll  an       seg
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 7'b1000000};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101, 7'b1000000};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 7'b1000000};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 7'b1000000};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 7'b1000000};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1110, 7'b1000000};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1110, 7'b1000000};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1110, 7'b1111001};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 7'b1111001};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 7'b0100100};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 7'b0100100};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 7'b0100100};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 7'b1000000};

    rst = 1'b1;
    tick_1hz = 1'b0; tick_scan = 1'b0; start_stop = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_an", 32'(an), 32'(4'b1110));
    chk("reset_seg", 32'(seg), 32'(7'b1000000));
    chk("reset_running", 32'(running), 32'(1'b0));
    chk("reset_rollover", 32'(rollover), 32'(1'b0));

    for (int i = 0; i <= 12; i++) begin
      step(vt[i].tick, vt[i].scan, vt[i].ss, vt[i].clr);
      chk($sformatf("vec%0d_an", i), 32'(an), 32'(vt[i].an));
      chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vt[i].seg));
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(vt[i].run));
      chk($sformatf("vec%0d_rollover", i), 32'(rollover), 32'(vt[i].roll));
      $display("vec %0d: in t=%0b sc=%0b ss=%0b clr=%0b -> an=%b seg=%b run=%0b roll=%0b",
               i, vt[i].tick, vt[i].scan, vt[i].ss, vt[i].clr, an, seg, running, rollover);
    end

    // Count to 01:15.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(75);
    check_time(1, 15);
    chk("run_0115", 32'(running), 32'(1'b1));

    // Pause freezes time; resume and advance by one.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(10);
    check_time(1, 15);
    chk("paused", 32'(running), 32'(1'b0));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    check_time(1, 16);

    // Walk up to 59:58, then across the wrap.
    ticks(3598 - 76);
    check_time(59, 58);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_wrap_rollover", 32'(rollover), 32'(1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_rollover", 32'(rollover), 32'(1'b1));
    chk("wrap_running", 32'(running), 32'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_wrap_rollover", 32'(rollover), 32'(1'b0));
    check_time(0, 0);
    $display("rollover sequence done");

    // Clear beats start_stop and tick at 12:34.
    ticks(754);
    check_time(12, 34);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_running", 32'(running), 32'(1'b0));
    chk("clr_rollover", 32'(rollover), 32'(1'b0));
    ticks(2);
    check_time(0, 0);

    // Coincident tick and start_stop: counted in RUN, ignored in PAUSE.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(9);
    check_time(0, 9);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("coinc_run_to_pause", 32'(running), 32'(1'b0));
    check_time(0, 10);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("coinc_pause_to_run", 32'(running), 32'(1'b1));
    check_time(0, 10);

    // Asynchronous reset while running, between clock edges.
    ticks(3);
    rst = 1'b1;
    #2;
    chk("async_an", 32'(an), 32'(4'b1110));
    chk("async_seg", 32'(seg), 32'(7'b1000000));
    chk("async_running", 32'(running), 32'(1'b0));
    chk("async_rollover", 32'(rollover), 32'(1'b0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    ticks(3);
    check_time(0, 0);
    $display("async reset sequence done");

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end
    $display("random phase done: model time %0d s, mode %0d", m_secs, m_mode);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
